// File: rtl/mfp_ahb_uart_tx_if.sv
// mfp_ahb_uart_tx_if -- AHB-Lite slave port bundle for the UART transmitter (rev 1.0).
`default_nettype none

interface mfp_ahb_uart_tx_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

`default_nettype wire

// File: rtl/mfp_ahb_uart_tx.sv
// mfp_ahb_uart_tx -- AHB-Lite memory-mapped 8N1 UART transmitter with byte FIFO (rev 1.0).
`default_nettype none

module mfp_ahb_uart_tx #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  mfp_ahb_uart_tx_if.slave ahb,
  output logic             UART_TX
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                       dp_valid;
  logic                       dp_write;
  logic                       dp_status;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       overflow;
  state_t                     state, state_next;
  logic [BAUD_W-1:0]          baud, baud_next;
  logic [2:0]                 bit_idx, bit_next;
  logic [7:0]                 shift, shift_next;
  logic                       pop;
  logic                       tx_next;

  logic wr_txdata, wr_status, full, empty, push, busy, baud_done;
  logic unused_bus;

  assign wr_txdata = dp_valid & dp_write & ~dp_status;
  assign wr_status = dp_valid & dp_write & dp_status;
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push      = wr_txdata & ~full;
  assign busy      = (state != IDLE) | ~empty;
  assign baud_done = (baud == BAUD_LAST);

  assign unused_bus = ^{ahb.HADDR[31:3], ahb.HADDR[1:0], ahb.HWDATA[31:8], ahb.HTRANS[0]};

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  // Combinational read mux: status reflects the registers as updated by the address-phase edge.
  assign ahb.HRDATA = (dp_valid & ~dp_write & dp_status)
                    ? {19'b0, 5'(count), 4'b0, overflow, empty, full, busy}
                    : 32'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_status <= 1'b0;
    end else begin
      dp_valid <= ahb.HSEL & ahb.HTRANS[1];
      if (ahb.HSEL & ahb.HTRANS[1]) begin
        dp_write  <= ahb.HWRITE;
        dp_status <= ahb.HADDR[2];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= ahb.HWDATA[7:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A full FIFO drops the byte even when a pop lands on the same edge.
      if (wr_txdata & full) overflow <= 1'b1;
      else if (wr_status)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      UART_TX <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      UART_TX <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_next = shift[0];
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mfp_ahb_uart_tx.sv
// tb_mfp_ahb_uart_tx -- randomized bench for mfp_ahb_uart_tx against a frame-timeline model.
`default_nettype none

module tb_mfp_ahb_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;

  mfp_ahb_uart_tx_if bus();

  mfp_ahb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(4)) dut (
    .HCLK(clk),
    .HRESETn(rst_n),
    .ahb(bus),
    .UART_TX(uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Model: each accepted byte is a frame with the edge it was written and the edge it was popped.
  int         fr_push[$];
  int         fr_pop[$];
  logic [7:0] fr_byte[$];
  int         ov_edge[$];
  logic       ov_val[$];
  int         rd_cyc[$];
  logic       rd_a2[$];
  int         lit_rd_cyc[$];
  logic [31:0] lit_rd_val[$];
  int         lit_tx_cyc[$];
  logic       lit_tx_val[$];
  int         last_pop = -100000;
  logic [31:0] pend_wdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  function automatic int count_at(int t);
    int c = 0;
    foreach (fr_push[i]) if (fr_push[i] <= t && fr_pop[i] > t) c++;
    return c;
  endfunction

  function automatic logic busy_at(int t);
    if (count_at(t) > 0) return 1'b1;
    foreach (fr_pop[i]) if (fr_pop[i] <= t && t <= fr_pop[i] + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ovf_at(int t);
    logic v = 1'b0;
    foreach (ov_edge[i]) if (ov_edge[i] <= t) v = ov_val[i];
    return v;
  endfunction

  function automatic logic tx_at(int t);
    int k;
    foreach (fr_pop[i]) begin
      if (t >= fr_pop[i] + 1 && t <= fr_pop[i] + FRAME) begin
        k = (t - fr_pop[i] - 1) / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fr_byte[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_at(int t);
    int c;
    c = count_at(t);
    return {19'b0, 5'(c), 4'b0, ovf_at(t), (c == 0), (c == DEPTH), busy_at(t)};
  endfunction

  task automatic model_clear();
    fr_push.delete(); fr_pop.delete(); fr_byte.delete();
    ov_edge.delete(); ov_val.delete();
    rd_cyc.delete(); rd_a2.delete();
    lit_rd_cyc.delete(); lit_rd_val.delete();
    lit_tx_cyc.delete(); lit_tx_val.delete();
    last_pop   = -100000;
    pend_wdata = '0;
  endtask

  // Compare process: every cycle the serial line, and read data on every read data phase.
  always @(negedge clk) begin
    check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("hresp", 32'(bus.HRESP), 32'd0);
    if (!rst_n) check("tx_in_reset", 32'(uart_tx), 32'd1);
    else        check("tx_model", 32'(uart_tx), 32'(tx_at(cyc)));
    for (int i = lit_tx_cyc.size() - 1; i >= 0; i--) begin
      if (lit_tx_cyc[i] == cyc) begin
        check("tx_literal", 32'(uart_tx), 32'(lit_tx_val[i]));
        lit_tx_cyc.delete(i); lit_tx_val.delete(i);
      end
    end
    for (int i = rd_cyc.size() - 1; i >= 0; i--) begin
      if (rd_cyc[i] == cyc) begin
        check(rd_a2[i] ? "status_model" : "txdata_read", bus.HRDATA, rd_a2[i] ? status_at(cyc) : 32'h0);
        rd_cyc.delete(i); rd_a2.delete(i);
      end
    end
    for (int i = lit_rd_cyc.size() - 1; i >= 0; i--) begin
      if (lit_rd_cyc[i] == cyc) begin
        check("hrdata_literal", bus.HRDATA, lit_rd_val[i]);
        lit_rd_cyc.delete(i); lit_rd_val.delete(i);
      end
    end
  end

  // One bus cycle: drive an address phase plus the previous write's data, and record its effect.
  task automatic issue(input logic sel, input logic [1:0] trans, input logic wr, input logic a2,
                       input logic [31:0] wd);
    int n, e, p;
    logic [31:0] addr;
    n = cyc;
    e = n + 2;
    addr = $urandom;
    addr[2] = a2;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HWDATA = pend_wdata;
    if (sel && trans[1]) begin
      if (wr && !a2) begin
        if (count_at(e - 1) == DEPTH) begin
          ov_edge.push_back(e); ov_val.push_back(1'b1);
        end else begin
          p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
          fr_push.push_back(e); fr_pop.push_back(p); fr_byte.push_back(wd[7:0]);
          last_pop = p;
        end
      end else if (wr) begin
        ov_edge.push_back(e); ov_val.push_back(1'b0);
      end else begin
        rd_cyc.push_back(n + 1); rd_a2.push_back(a2);
      end
    end
    pend_wdata = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    issue(1'b0, 2'b00, 1'b0, 1'b0, $urandom);
  endtask

  task automatic write_tx(input logic [7:0] b);
    logic [31:0] wd;
    wd = $urandom;
    wd[7:0] = b;
    issue(1'b1, 2'b10, 1'b1, 1'b0, wd);
  endtask

  task automatic read_lit(input logic a2, input logic [31:0] want);
    lit_rd_cyc.push_back(cyc + 1); lit_rd_val.push_back(want);
    issue(1'b1, 2'b10, 1'b0, a2, $urandom);
  endtask

  task automatic drain();
    while (cyc < last_pop + FRAME + 2) idle();
  endtask

  task automatic tx_lit(input int c, input logic v);
    lit_tx_cyc.push_back(c); lit_tx_val.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d: got timeout want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r;
    logic [7:0] a5;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    tx_lit(cyc + 1, 1'b1);
    read_lit(1'b1, 32'h0000_0004);
    idle(); idle();

    // Single byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
    a5 = 8'hA5;
    n0 = cyc;
    tx_lit(n0 + 3, 1'b1);
    tx_lit(n0 + 5, 1'b0);
    for (int k = 0; k < 8; k++) tx_lit(n0 + 4 + (k + 1) * CPB + 1, a5[k]);
    tx_lit(n0 + 4 + 9 * CPB + 1, 1'b1);
    tx_lit(n0 + 44, 1'b1);
    write_tx(a5);
    drain();
    read_lit(1'b1, 32'h0000_0004);

    // Back-to-back bytes form contiguous frames
    n0 = cyc;
    tx_lit(n0 + 43, 1'b1);
    tx_lit(n0 + 44, 1'b0);
    tx_lit(n0 + 83, 1'b1);
    tx_lit(n0 + 84, 1'b0);
    tx_lit(n0 + 124, 1'b1);
    write_tx(8'h01); write_tx(8'h02); write_tx(8'h03);
    while (cyc < n0 + 10) idle();
    read_lit(1'b1, 32'h0000_0201);
    drain();

    // TXDATA reads return zero; unselected and BUSY transfers have no effect
    read_lit(1'b0, 32'h0000_0000);
    issue(1'b0, 2'b10, 1'b0, 1'b1, $urandom);
    issue(1'b0, 2'b10, 1'b1, 1'b0, 32'h0000_00FF);
    issue(1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_00EE);
    idle();
    read_lit(1'b1, 32'h0000_0004);
    idle();

    // Overflow: 18 writes into a 16-deep FIFO with one byte already popped
    for (int i = 0; i < 18; i++) write_tx(8'(i));
    read_lit(1'b1, 32'h0000_100B);
    issue(1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_0000);
    read_lit(1'b1, 32'h0000_1003);
    drain();
    read_lit(1'b1, 32'h0000_0004);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (r < 6)        write_tx(8'($urandom));
      else if (r < 12)  issue(1'b1, 2'b10, 1'b0, 1'b1, $urandom);
      else if (r < 14)  issue(1'b1, 2'b10, 1'b0, 1'b0, $urandom);
      else if (r < 16)  issue(1'b1, 2'($urandom_range(2, 3)), 1'b1, 1'b1, $urandom);
      else if (r < 20)  issue(1'b0, 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
      else if (r < 22)  issue(1'b1, 2'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), $urandom);
      else if (r == 199) begin
        for (int j = 0; j < 20; j++) write_tx(8'($urandom));
      end else idle();
    end
    drain();
    issue(1'b1, 2'b10, 1'b1, 1'b1, 32'h0);
    idle();
    read_lit(1'b1, 32'h0000_0004);

    // Reset during data bit 3 of the first of two queued frames
    n0 = cyc;
    write_tx(8'h55);
    write_tx(8'h66);
    while (cyc < n0 + 21) idle();
    check("tx_before_reset", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    model_clear();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    #1;
    check("tx_async_reset", 32'(uart_tx), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) idle();
    read_lit(1'b1, 32'h0000_0004);
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mfp_ahb_uart_tx.md
# mfp_ahb_uart_tx

Memory-mapped UART transmitter on the AHB-Lite bus, the outbound counterpart of the serial loader's UART receiver. Software stores bytes into a data register. They are buffered in a FIFO and shifted out on `UART_TX` as 8N1 frames, LSB first. The block is a zero-wait-state AHB-Lite slave selected by the bus decoder through `HSEL`, and it sits alongside the other I/O slaves inside the AHB fabric.

## Interface
- `CLKS_PER_BIT`, 434, HCLK cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH_LOG2`, 4, the FIFO holds 2^N bytes (default 16).

Ports:
- `HCLK`  in  1  system clock; every flop is on the rising edge.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `HSEL`  in  1  slave select from the decoder.
- `HADDR`  in  32  address; only `HADDR[2]` is decoded (0 = TXDATA, 1 = STATUS).
- `HTRANS`  in  2  a transfer is active when `HTRANS[1]` = 1 (NONSEQ/SEQ).
- `HWRITE`  in  1  write = 1.
- `HWDATA`  in  32  write data, valid in the data phase.
- `HRDATA`  out  32  read data, valid in the data phase.
- `HREADYOUT`  out  1  constant 1 (no wait states).
- `HRESP`  out  1  constant 0 (OKAY).
- `UART_TX`  out  1  serial output; idles high.

## Operation
- Address phase: when `HSEL & HTRANS[1]` is set, latch `HWRITE` and `HADDR[2]` into data-phase registers. Otherwise clear the latched valid bit.
- Data-phase write to TXDATA:
  - Push `HWDATA[7:0]` into the FIFO. `HSIZE` and byte lanes are ignored; software uses word stores.
  - The push uses the FIFO full flag as registered before this edge. If full, the byte is dropped and sticky `overflow` is set, even if a pop coincides.
- Data-phase write to STATUS: clear `overflow` whatever the data value.
- Reads return the following:
  - TXDATA reads return 0.
  - STATUS reads return {19'b0, count[12:8], 4'b0, overflow[3], empty[2], full[1], busy[0]}. `count` is the FIFO occupancy (0..16, `FIFO_DEPTH_LOG2`+1 bits, zero-extended to 5).
  - `busy` = (state != IDLE) | !empty.
- FIFO: circular buffer with read and write pointers that wrap modulo depth, plus an occupancy counter. A push and a pop in the same cycle leave `count` unchanged.
- Transmit FSM states are IDLE, START, DATA, STOP. It uses a baud counter (0..`CLKS_PER_BIT`-1), a 3-bit bit index and an 8-bit shift register.
  - IDLE: `UART_TX`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `UART_TX`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `UART_TX`=shift[0] for `CLKS_PER_BIT` cycles per bit, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: `UART_TX`=1 for `CLKS_PER_BIT` cycles. At the end of the stop bit, if the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- `UART_TX` is driven from a flop (glitch-free).

## Timing
- Reset values: `UART_TX`=1, state=IDLE, FIFO empty (count 0), `overflow`=0, counters 0, `HRDATA`=0, data-phase valid=0. `HREADYOUT`=1 and `HRESP`=0 at all times.
- Reset asserted mid-frame: `UART_TX` returns to 1 immediately (asynchronously), and the frame and queued bytes are discarded.
- Write latency: call the edge that completes the TXDATA data phase E. The FIFO is written at E. IDLE pops at E+1, and `UART_TX` falls after E+2's flop update, i.e. it is low in the cycle following E+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles. Queued bytes are sent with zero idle gap between stop and start bits.
- STATUS read data reflects register state at the end of the address phase, plus any update made by the edge opening the data phase.
- Back-to-back AHB writes, one per cycle, are sustained with no stalls.

## Test plan
- Reset check: with `HRESETn` low then released, `UART_TX`=1 and STATUS reads 0x00000004.
- Single byte (`CLKS_PER_BIT`=4): write 0xA5 to TXDATA. `UART_TX` shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 4 cycles (40 cycles total). After that, `busy` reads 0 and STATUS reads 0x00000004.
- Back-to-back bytes: write 0x01, 0x02, 0x03 in consecutive cycles. Three contiguous frames follow with no idle cycles (120 cycles at `CLKS_PER_BIT`=4). During the first frame STATUS reads count=2.
- Overflow: 18 consecutive single-cycle writes of 0x00..0x11. Bytes 0x00..0x10 (17 bytes) are transmitted in order and 0x11 is dropped. STATUS shows bit3=1 and bit1=1 immediately after the burst. A STATUS write then clears bit3.
- Reset mid-frame: write 0x55, then 0x66, and assert `HRESETn` during data bit 3 of the first frame. `UART_TX`=1 immediately, and after release no further frame is sent.
- Reads: a TXDATA read returns 0x00000000; a STATUS read with `HSEL`=0 during the address phase causes no state change.
